// File: rtl/btn_ctrl_pkg.sv
// btn_ctrl_pkg: shared mode type, default divider and width helper for the stopwatch buttons.
package btn_ctrl_pkg;
  typedef enum logic {RUN = 1'b0, PAUSED = 1'b1} mode_t;
  localparam int DIV_DEFAULT = 250000;
  function automatic int clog2(input int v);
    return $clog2(v);
  endfunction
endpackage

// File: rtl/btn_db.sv
// btn_db: synchronizes one raw button, debounces it on sample ticks and emits a one-cycle press.
module btn_db (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic sample_tick,
  output logic level,
  output logic press
);
  logic [1:0] sync_q, sh_q, sh_d;
  logic level_q, level_d, level_dly_q, press_q;
  // level follows two agreeing samples and otherwise holds, so sub-period glitches vanish
  always_comb begin
    sh_d = sample_tick ? {sh_q[0], sync_q[1]} : sh_q;
    level_d = !sample_tick ? level_q : (sh_d == 2'b11) ? 1'b1 : (sh_d == 2'b00) ? 1'b0 : level_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= '0;
      sh_q <= '0;
      level_q <= 1'b0;
      level_dly_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      sh_q <= sh_d;
      level_q <= level_d;
      level_dly_q <= level_q;
      press_q <= level_q & ~level_dly_q;
    end
  assign level = level_q;
  assign press = press_q;
endmodule

// File: rtl/btn_ctrl.sv
// btn_ctrl: debounce sample divider plus pause/reset mode FSM driving the stopwatch counter.
module btn_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_pause,
  input  logic btn_rst,
  output logic sample_tick,
  output logic paused,
  output logic clr
);
  localparam int CW = clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] cnt_q;
  logic tick_q, clr_q;
  logic level_pause, press_pause, level_rst, press_rst;
  mode_t state_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      tick_q <= cnt_q == LAST;
    end
  btn_db u_pause (.clk(clk), .rst(rst), .btn(btn_pause), .sample_tick(tick_q), .level(level_pause), .press(press_pause));
  btn_db u_rst (.clk(clk), .rst(rst), .btn(btn_rst), .sample_tick(tick_q), .level(level_rst), .press(press_rst));
  // reset press wins over pause; pause is locked out while the reset button is held
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= RUN;
      clr_q <= 1'b0;
    end else begin
      clr_q <= press_rst;
      state_q <= press_rst ? RUN : (press_pause && level_pause && !level_rst) ? ((state_q == RUN) ? PAUSED : RUN) : state_q;
    end
  assign sample_tick = tick_q;
  assign paused = state_q == PAUSED;
  assign clr = clr_q;
endmodule
